// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU writes take priority, long-latency results queue in a FIFO,
// and a busy scoreboard feeds decode stalls. Optional bypass outputs are built when WB_BYPASS_EN is defined.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_we,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [4:0]    lu_rd,
    input  logic [31:0]   lu_data,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rd,
    input  logic [4:0]    chk_rs1,
    input  logic [4:0]    chk_rs2,
    input  logic [4:0]    chk_rd,
    output logic          stall,
    output logic          we,
    output logic [4:0]    rd,
    output logic [31:0]   indata,
    output logic [AW:0]   fifo_count,
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic [31:0]   fwd1_data,
    output logic [31:0]   fwd2_data
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    mem_rd_q   [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [31:0]   busy_q, busy_d;
    logic          we_q;
    logic [4:0]    rd_q;
    logic [31:0]   indata_q;

    logic          alu_sel, pop, push;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign head_rd   = mem_rd_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];

    // A suppressed x0 ALU write leaves the port free for the FIFO head.
    assign alu_sel  = alu_we && (alu_rd != 5'd0);
    assign pop      = !alu_sel && (count_q != '0);
    assign lu_ready = !reset && (count_q < FULL);
    assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);

    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[head_rd] = 1'b0;
        // Applied after the clear so a same-register issue wins.
        if (iss_valid && (iss_rd != 5'd0))
            busy_d[iss_rd] = 1'b1;
    end

    assign stall = ((chk_rs1 != 5'd0) && busy_q[chk_rs1]) ||
                   ((chk_rs2 != 5'd0) && busy_q[chk_rs2]) ||
                   ((chk_rd  != 5'd0) && busy_q[chk_rd]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= lu_rd;
            mem_data_q[wr_ptr_q] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            indata_q <= 32'd0;
        end else begin
            if (alu_sel) begin
                we_q     <= 1'b1;
                rd_q     <= alu_rd;
                indata_q <= alu_data;
            end else if (pop) begin
                we_q     <= 1'b1;
                rd_q     <= head_rd;
                indata_q <= head_data;
            end else begin
                we_q     <= 1'b0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            busy_q <= busy_d;
        end
    end

    assign we         = we_q;
    assign rd         = rd_q;
    assign indata     = indata_q;
    assign fifo_count = count_q;

`ifdef WB_BYPASS_EN
    // Covers the cycle where the register file has not yet absorbed the write.
    assign fwd1_hit  = we_q && (rd_q != 5'd0) && (rd_q == chk_rs1);
    assign fwd2_hit  = we_q && (rd_q != 5'd0) && (rd_q == chk_rs2);
    assign fwd1_data = fwd1_hit ? indata_q : 32'd0;
    assign fwd2_data = fwd2_hit ? indata_q : 32'd0;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = 32'd0;
    assign fwd2_data = 32'd0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && iss_valid && (iss_rd != 5'd0))
            assert (!busy_q[iss_rd]) else $error("issue to already-busy register x%0d", iss_rd);
    end
`endif

endmodule
